// File: rtl/freq_metre_multi.sv
// rtl/freq_metre_multi.sv - multi-channel frequency / period meter
// Counts rising edges of one selected asynchronous input over a gate, or times the gap between two edges.
module freq_metre_multi #(
    parameter int NB_CH          = 4,
    parameter int W              = 22,
    parameter int GATE_CYCLES    = 50000000,
    parameter int TIMEOUT_CYCLES = 100000000,
    localparam int CW            = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic             ClkRef,
    input  logic             Rst_n,
    input  logic [NB_CH-1:0] SigIn,
    input  logic [CW-1:0]    ChSel,
    input  logic             Mode,
    input  logic             Continu,
    input  logic             Start,
    output logic             Busy,
    output logic             Valid,
    output logic [W-1:0]     Mesure,
    output logic [CW-1:0]    ChOut,
    output logic             Overflow,
    output logic             Timeout
);

    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0]  CNT_MAX  = {W{1'b1}};
    localparam logic [GW-1:0] GATE_END = GW'(GATE_CYCLES);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state, w_state_next;

    logic [NB_CH-1:0] r_sync1, r_sync2, r_hist;
    logic [NB_CH-1:0] w_edge;
    logic             w_ch_edge;

    logic [CW-1:0] r_ch;
    logic          r_mode;
    logic [W-1:0]  r_cnt;
    logic          r_ovf;
    logic [GW-1:0] r_gate;
    logic [TW-1:0] r_to;
    logic          r_tflag;

    logic          r_valid;
    logic [W-1:0]  r_mesure;
    logic [CW-1:0] r_chout;
    logic          r_ovf_o;
    logic          r_to_o;

    logic w_load, w_restart, w_arm_hit, w_cnt_inc, w_set_to, w_gate_run, w_to_run;

    assign w_edge    = r_sync2 & ~r_hist;
    assign w_ch_edge = w_edge[r_ch];

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_restart    = 1'b0;
        w_arm_hit    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_set_to     = 1'b0;
        w_gate_run   = 1'b0;
        w_to_run     = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_load       = 1'b1;
                    w_state_next = Mode ? ARM : MEAS;
                end
            end
            ARM: begin
                w_to_run = 1'b1;
                if (w_ch_edge) begin
                    w_arm_hit    = 1'b1;
                    w_state_next = MEAS;
                end else if (r_to == TO_LAST) begin
                    w_set_to     = 1'b1;
                    w_state_next = DONE;
                end
            end
            MEAS: begin
                if (!r_mode) begin
                    // r_gate==0 is the setup cycle; gate cycles are r_gate 1..GATE_CYCLES,
                    // the last one still counting its edge.
                    w_gate_run = 1'b1;
                    w_cnt_inc  = w_ch_edge && (r_gate != '0);
                    if (r_gate == GATE_END) begin
                        w_state_next = DONE;
                    end
                end else begin
                    w_to_run  = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (w_ch_edge) begin
                        w_state_next = DONE;
                    end else if (r_to == TO_LAST) begin
                        w_set_to     = 1'b1;
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (Continu) begin
                    w_restart    = 1'b1;
                    w_state_next = r_mode ? ARM : MEAS;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge ClkRef) begin
        if (!Rst_n) begin
            r_state  <= IDLE;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_hist   <= '0;
            r_ch     <= '0;
            r_mode   <= 1'b0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_gate   <= '0;
            r_to     <= '0;
            r_tflag  <= 1'b0;
            r_valid  <= 1'b0;
            r_mesure <= '0;
            r_chout  <= '0;
            r_ovf_o  <= 1'b0;
            r_to_o   <= 1'b0;
        end else begin
            r_sync1 <= SigIn;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_state <= w_state_next;
            r_valid <= (r_state == DONE);

            if (w_load) begin
                r_ch   <= ChSel;
                r_mode <= Mode;
            end

            if (w_load || w_restart) begin
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
                r_gate  <= '0;
                r_to    <= '0;
                r_tflag <= 1'b0;
            end else if (w_arm_hit) begin
                r_cnt <= '0;
                r_to  <= '0;
            end else begin
                if (w_gate_run) begin
                    r_gate <= r_gate + GW'(1);
                end
                if (w_to_run) begin
                    r_to <= r_to + TW'(1);
                end
                if (w_cnt_inc) begin
                    if (r_cnt == CNT_MAX) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + W'(1);
                    end
                end
                if (w_set_to) begin
                    r_tflag <= 1'b1;
                end
            end

            if (r_state == DONE) begin
                r_mesure <= r_tflag ? '0 : r_cnt;
                r_chout  <= r_ch;
                r_ovf_o  <= r_ovf & ~r_tflag;
                r_to_o   <= r_tflag;
            end
        end
    end

    assign Busy     = (r_state != IDLE);
    assign Valid    = r_valid;
    assign Mesure   = r_mesure;
    assign ChOut    = r_chout;
    assign Overflow = r_ovf_o;
    assign Timeout  = r_to_o;

endmodule

// File: tb/tb_freq_metre_multi.sv
// tb/tb_freq_metre_multi.sv - directed scoreboard bench for freq_metre_multi
module tb_freq_metre_multi;

    localparam int NB_CH = 4;
    localparam int W     = 7;
    localparam int GATE  = 100;
    localparam int TMO   = 200;

    typedef struct packed {
        logic [6:0] m;
        logic [1:0] ch;
        logic       ov;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sig_in = '0;
    logic [1:0] ch_sel = '0;
    logic       mode = 1'b0;
    logic       continu = 1'b0;
    logic       start = 1'b0;
    logic       busy, valid, ovf, tmo;
    logic [6:0] mesure;
    logic [1:0] chout;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   cyc = 0;
    int   per [4] = '{150, 37, 10, 0};
    int   ph  [4] = '{0, 3, 5, 0};
    exp_t sb[$];

    freq_metre_multi #(
        .NB_CH(NB_CH), .W(W), .GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .ClkRef(clk), .Rst_n(rst_n), .SigIn(sig_in), .ChSel(ch_sel), .Mode(mode),
        .Continu(continu), .Start(start), .Busy(busy), .Valid(valid), .Mesure(mesure),
        .ChOut(chout), .Overflow(ovf), .Timeout(tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (per[i] == 0) begin
                sig_in[i] = 1'b0;
            end else begin
                ph[i]     = (ph[i] + 1) % per[i];
                sig_in[i] = (ph[i] < per[i] / 2);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            exp_t e;
            n_valid++;
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_valid: got valid with empty scoreboard, want no valid");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_mesure", 32'(mesure), 32'(e.m));
                check("sb_chout", 32'(chout), 32'(e.ch));
                check("sb_overflow", 32'(ovf), 32'(e.ov));
                check("sb_timeout", 32'(tmo), 32'(e.to));
            end
        end
    end

    task automatic do_start(input logic [1:0] ch, input logic md, output int t0);
        @(negedge clk);
        ch_sel = ch;
        mode   = md;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_valid(input string tag, input int budget, output int tv);
        tv = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                tv = cyc;
                break;
            end
        end
        n_cmp++;
        assert (tv >= 0) else begin
            n_err++;
            $error("FAIL %s: got no valid within %0d cycles, want valid", tag, budget);
        end
    endtask

    task automatic quiet_window(input string tag, input int len);
        int v0;
        @(negedge clk);
        v0 = n_valid;
        repeat (len) @(negedge clk);
        check(tag, 32'(n_valid - v0), 32'd0);
    endtask

    initial begin
        int t0, tv, tv1, tv2, tv3, tv4, v0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_mesure", 32'(mesure), 32'd0);
        check("rst_chout", 32'(chout), 32'd0);
        check("rst_overflow", 32'(ovf), 32'd0);
        check("rst_timeout", 32'(tmo), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // frequency, channel 2, 10-cycle period
        sb.push_back('{m: 7'd10, ch: 2'd2, ov: 1'b0, to: 1'b0});
        do_start(2'd2, 1'b0, t0);
        check("freq_busy", 32'(busy), 32'd1);
        wait_valid("freq_valid", 150, tv);
        check("freq_latency", 32'(tv - t0), 32'd102);
        check("freq_busy_after", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        // period, channel 1, 37-cycle period; ChSel/Mode change while busy
        sb.push_back('{m: 7'd37, ch: 2'd1, ov: 1'b0, to: 1'b0});
        do_start(2'd1, 1'b1, t0);
        @(negedge clk);
        ch_sel = 2'd3;
        mode   = 1'b0;
        check("period_busy", 32'(busy), 32'd1);
        wait_valid("period_valid", 300, tv);
        check("period_busy_after", 32'(busy), 32'd0);
        quiet_window("period_single_valid", 60);

        // saturation, channel 0, 150-cycle period
        sb.push_back('{m: 7'd127, ch: 2'd0, ov: 1'b1, to: 1'b0});
        do_start(2'd0, 1'b1, t0);
        wait_valid("sat_valid", 400, tv);
        repeat (5) @(negedge clk);

        // timeout, channel 3 held low: 200 ARM cycles then DONE
        sb.push_back('{m: 7'd0, ch: 2'd3, ov: 1'b0, to: 1'b1});
        do_start(2'd3, 1'b1, t0);
        wait_valid("tmo_valid", 300, tv);
        check("tmo_latency", 32'(tv - t0), 32'd201);
        repeat (5) @(negedge clk);

        // Start mid-gate must be ignored
        sb.push_back('{m: 7'd10, ch: 2'd2, ov: 1'b0, to: 1'b0});
        do_start(2'd2, 1'b0, t0);
        repeat (49) @(negedge clk);
        start  = 1'b1;
        ch_sel = 2'd0;
        mode   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("ctl_valid", 150, tv);
        check("ctl_latency", 32'(tv - t0), 32'd102);
        quiet_window("ctl_single_valid", 150);

        // reset mid-gate aborts without Valid; Start accepted on first released cycle
        v0 = n_valid;
        do_start(2'd2, 1'b0, t0);
        repeat (59) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_no_valid", 32'(n_valid - v0), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mesure", 32'(mesure), 32'd0);
        check("abort_chout", 32'(chout), 32'd0);
        sb.push_back('{m: 7'd10, ch: 2'd2, ov: 1'b0, to: 1'b0});
        rst_n  = 1'b1;
        start  = 1'b1;
        ch_sel = 2'd2;
        mode   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        check("post_rst_busy", 32'(busy), 32'd1);
        wait_valid("post_rst_valid", 150, tv);
        check("post_rst_latency", 32'(tv - t0), 32'd102);
        repeat (5) @(negedge clk);

        // continuous mode
        for (int k = 0; k < 4; k++) sb.push_back('{m: 7'd10, ch: 2'd2, ov: 1'b0, to: 1'b0});
        continu = 1'b1;
        do_start(2'd2, 1'b0, t0);
        wait_valid("cont_v1", 150, tv1);
        check("cont_lat1", 32'(tv1 - t0), 32'd102);
        wait_valid("cont_v2", 150, tv2);
        check("cont_lat2", 32'(tv2 - tv1), 32'd102);
        check("cont_busy", 32'(busy), 32'd1);
        wait_valid("cont_v3", 150, tv3);
        check("cont_lat3", 32'(tv3 - tv2), 32'd102);
        continu = 1'b0;
        wait_valid("cont_v4", 150, tv4);
        check("cont_lat4", 32'(tv4 - tv3), 32'd102);
        check("cont_busy_end", 32'(busy), 32'd0);
        quiet_window("cont_stopped", 150);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
